mix_columns_seq: RTL
====================

// Module: mix_columns_seq
// PURPOSE
//  Iterative AES MixColumns / InvMixColumns engine for a LENGTH-bit state with a valid/ready handshake.
//  Processes LANES columns per cycle, trading area for latency.
//  Sits between ShiftRows and AddRoundKey in the round datapath.
//  Supersedes the purely combinational column mixer.
// PARAMETERS
//  BYTE    8    byte width; must be 8 (GF(2^8) arithmetic)
//  DWORD   32   column width; must equal 4*BYTE
//  LENGTH  128  state width; must be a multiple of DWORD; COLS = LENGTH/DWORD
//  LANES   1    columns mixed per cycle; must divide COLS; STEPS = COLS/LANES
// PORTS
//  clk        in   1       clock; all logic is on the rising edge
//  rst_n      in   1       synchronous, active-low reset
//  in_valid   in   1       in_data/in_inv are valid
//  in_ready   out  1       engine can accept a block
//  in_data    in   LENGTH  state; column c = in_data[c*DWORD +: DWORD]; row 0 = column MSB byte
//  in_inv     in   1       1 = InvMixColumns (only with MIX_COLUMNS_INV_EN)
//  out_valid  out  1       out_data holds a finished block
//  out_ready  in   1       consumer takes out_data
//  out_data   out  LENGTH  mixed state, same column/row layout as in_data
//  busy       out  1       high while the FSM is in BUSY
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): state=IDLE, column index=0, out_valid=0, out_data=0, in_inv reg=0.
//    in_ready is 0 while rst_n=0 and 1 from the first cycle after release.
//  - FSM IDLE -> BUSY: in_valid & in_ready at an edge. Capture in_data into the state register,
//    capture in_inv, set idx=0. in_ready=1 only in IDLE.
//  - FSM BUSY: each edge replaces columns idx*LANES .. idx*LANES+LANES-1 in place with their mixed value.
//    Then idx increments. After the edge with idx=STEPS-1, go to DONE.
//  - FSM DONE: out_valid=1, and out_data = the state register, held stable until out_valid & out_ready.
//    On that edge go to IDLE. No new block is accepted in the same cycle.
//  - Latency: out_valid rises STEPS cycles after the accept edge.
//    Throughput: one block per STEPS+2 cycles, with out_ready held high.
//  - Forward mix per column [a0..a3]: r_i = 2*a_i ^ 3*a_{i+1} ^ a_{i+2} ^ a_{i+3}, indices mod 4.
//    xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
//  - Boundary cases:
//    - in_valid while BUSY/DONE: ignored, not queued.
//    - out_ready without out_valid: no effect.
//    - in_data changing after accept: no effect.
//    - rst_n low mid-BUSY/DONE: block discarded, no out_valid.
//    - idx wraps to 0 only via IDLE.
// CONFIGURATION
//  - MIX_COLUMNS_INV_EN defined: when in_inv=1, columns use InvMixColumns coefficients {0E,0B,0D,09}.
//    The captured mode applies to the whole block.
//  - Undefined: the inverse logic is not built, in_inv is ignored, and the engine is forward-only.
//    The port is still present.
// STRUCTURE
//  - Shared header aes_defs.vh: AES_POLY (8'h1B), xtime/gmul function macros, AES_BYTE/AES_DWORD defaults.
//  - Sub-module mix_column_word: combinational, one DWORD in/out plus inv.
//    Instantiated LANES times by generate.
//  - Top level: FSM, idx counter, state register, handshake.
// TESTING
//  - FIPS-197 column: d4bf5d30 fwd -> 046681e5.
//    db135345 -> 8e4da1bc.
//    f20a225c -> 9fdc589d.
//    c6c6c6c6 -> c6c6c6c6.
//  - Full block {046681e5,e0cb199a,48f8d37a,2806264c} (cols 3..0) LANES=1.
//    out_valid exactly 4 cycles after accept. Check result against the reference model.
//  - With MIX_COLUMNS_INV_EN: inv of 8e4da1bc -> db135345. Random 1000 blocks: inv(fwd(x)) == x.
//  - Backpressure: out_ready=0 for 10 cycles -> out_data stable, in_ready=0.
//    in_valid pulses during that time are dropped.
//  - Reset: rst_n=0 on cycle 2 of BUSY -> out_valid stays 0.
//    in_ready=1 one cycle after release, and the next block processes correctly.
//  - LANES=2 and LANES=4: latency 2 and 1 cycles respectively. Results identical to LANES=1.

Source files
------------

// File: rtl/mix_columns_seq_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers for the MixColumns engine.
package mix_columns_seq_pkg;

  localparam int AES_BYTE  = 8;
  localparam int AES_DWORD = 32;
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = x;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // One output row from a column rotated so that 'a' is the row's own byte.
  function automatic logic [7:0] fwd_byte(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return xtime(a) ^ xtime(b) ^ b ^ c ^ d;
  endfunction

  function automatic logic [7:0] inv_byte(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return gmul(a, 8'h0E) ^ gmul(b, 8'h0B) ^ gmul(c, 8'h0D) ^ gmul(d, 8'h09);
  endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Block handshake between the round datapath and the MixColumns engine.
interface mix_columns_seq_if #(
  parameter int LENGTH = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [LENGTH-1:0] in_data;
  logic              in_inv;
  logic              out_valid;
  logic              out_ready;
  logic [LENGTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mix_columns_seq_mix_column_word.sv
// Combinational mixer for one column; inverse coefficients only exist when
// MIX_COLUMNS_INV_EN is defined, otherwise inv is ignored.
module mix_column_word
  import mix_columns_seq_pkg::*;
#(
  parameter int BYTE  = AES_BYTE,
  parameter int DWORD = AES_DWORD
) (
  input  logic [DWORD-1:0] col,
  input  logic             inv,
  output logic [DWORD-1:0] mixed
);

  logic [BYTE-1:0] a0, a1, a2, a3;
  logic [DWORD-1:0] fwd;

  // Row 0 is the most significant byte of the column.
  assign a0 = col[4*BYTE-1 -: BYTE];
  assign a1 = col[3*BYTE-1 -: BYTE];
  assign a2 = col[2*BYTE-1 -: BYTE];
  assign a3 = col[1*BYTE-1 -: BYTE];

  assign fwd = {fwd_byte(a0, a1, a2, a3), fwd_byte(a1, a2, a3, a0),
                fwd_byte(a2, a3, a0, a1), fwd_byte(a3, a0, a1, a2)};

`ifdef MIX_COLUMNS_INV_EN
  logic [DWORD-1:0] rev;

  assign rev = {inv_byte(a0, a1, a2, a3), inv_byte(a1, a2, a3, a0),
                inv_byte(a2, a3, a0, a1), inv_byte(a3, a0, a1, a2)};

  assign mixed = inv ? rev : fwd;
`else
  logic unused_inv;

  assign unused_inv = inv;
  assign mixed      = fwd;
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative MixColumns engine: LANES columns per cycle, COLS/LANES cycles per block.
// Define MIX_COLUMNS_INV_EN to build the InvMixColumns path selected by in_inv.
//
// state | meaning
// IDLE  | in_ready high, waiting for a block
// BUSY  | mixing LANES columns of the state register per cycle
// DONE  | out_valid high, out_data held until out_ready
module mix_columns_seq
  import mix_columns_seq_pkg::*;
#(
  parameter int BYTE   = AES_BYTE,
  parameter int DWORD  = AES_DWORD,
  parameter int LENGTH = 128,
  parameter int LANES  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mix_columns_seq_if.slave   bus,
  output logic               busy
);

  localparam int COLS  = LENGTH / DWORD;
  localparam int STEPS = COLS / LANES;
  localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(STEPS - 1);

  state_e            state;
  logic [IDXW-1:0]   idx;
  logic [LENGTH-1:0] blk;
  logic [LENGTH-1:0] blk_next;
  logic              inv_q;
  logic [DWORD-1:0]  col_in  [LANES];
  logic [DWORD-1:0]  col_out [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign col_in[g] = blk[(int'(idx) * LANES + g) * DWORD +: DWORD];

    mix_column_word #(
      .BYTE  (BYTE),
      .DWORD (DWORD)
    ) u_mix (
      .col   (col_in[g]),
      .inv   (inv_q),
      .mixed (col_out[g])
    );
  end

  // Columns of the current step are replaced in place; the rest pass through.
  always_comb begin
    blk_next = blk;
    for (int l = 0; l < LANES; l++) begin
      blk_next[(int'(idx) * LANES + l) * DWORD +: DWORD] = col_out[l];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      blk           <= '0;
      inv_q         <= 1'b0;
      busy          <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            blk          <= bus.in_data;
            inv_q        <= bus.in_inv;
            idx          <= '0;
            busy         <= 1'b1;
            bus.in_ready <= 1'b0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          blk <= blk_next;
          if (idx == IDX_LAST) begin
            busy          <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_data  <= blk_next;
            state         <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
